// File: rtl/fft_pkg.sv
// Shared types for the time-multiplexed FFT stage: FSM states and the twiddle ROM generator.
// Twiddles are signed Q2.(w-2) values, rounded to nearest at elaboration time.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int  TW_INT_BITS = 2;
    localparam real TWO_PI      = 6.283185307179586;

    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
    } tw_t;

    function automatic int tw_frac(input int msb);
        return msb / 2 - TW_INT_BITS;
    endfunction

    function automatic int round_nearest(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    // W^k = cos(2*pi*k/n) - j*sin(2*pi*k/n), scaled by 2^frac
    function automatic tw_t twiddle(input int k, input int n, input int frac);
        real  ang;
        real  sc;
        tw_t  t;
        ang  = TWO_PI * real'(k) / real'(n);
        sc   = real'(1 << frac);
        t.re = round_nearest($cos(ang) * sc);
        t.im = round_nearest(-$sin(ang) * sc);
        return t;
    endfunction

endpackage

// File: rtl/bf_pipe.sv
// One radix-2 DIF butterfly, two register stages: D=A+B, E=(A-B)*W. Valid in, valid out, no stall.
// FFT_STAGE_SCALE_EN halves the sum/difference (floor) so the butterfly cannot overflow.
module bf_pipe
    import fft_pkg::*;
#(
    parameter int MSB = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_vld,
    input  logic [MSB-1:0]     a,
    input  logic [MSB-1:0]     b,
    input  logic [MSB/2-1:0]   tw_re,
    input  logic [MSB/2-1:0]   tw_im,
    output logic               out_vld,
    output logic [MSB-1:0]     d,
    output logic [MSB-1:0]     e
);

    localparam int W  = MSB / 2;
    localparam int F  = tw_frac(MSB);
    localparam int PW = 2 * W + 1;
    localparam logic signed [PW-1:0] RND = PW'((1 << F) >> 1);

    logic signed [W-1:0] a_re, a_im, b_re, b_im;
    logic signed [W-1:0] s_re, s_im, x_re, x_im;
    logic signed [W-1:0] d1_re, d1_im, x1_re, x1_im, w1_re, w1_im;
    logic signed [PW-1:0] p_re, p_im;
    logic signed [W-1:0] e_re, e_im;
    logic                v1;

    assign a_re = a[MSB-1:W];
    assign a_im = a[W-1:0];
    assign b_re = b[MSB-1:W];
    assign b_im = b[W-1:0];

`ifdef FFT_STAGE_SCALE_EN
    assign s_re = W'(($signed({a_re[W-1], a_re}) + $signed({b_re[W-1], b_re})) >>> 1);
    assign s_im = W'(($signed({a_im[W-1], a_im}) + $signed({b_im[W-1], b_im})) >>> 1);
    assign x_re = W'(($signed({a_re[W-1], a_re}) - $signed({b_re[W-1], b_re})) >>> 1);
    assign x_im = W'(($signed({a_im[W-1], a_im}) - $signed({b_im[W-1], b_im})) >>> 1);
`else
    assign s_re = a_re + b_re;
    assign s_im = a_im + b_im;
    assign x_re = a_re - b_re;
    assign x_im = a_im - b_im;
`endif

    function automatic logic signed [PW-1:0] sx(input logic signed [W-1:0] v);
        return {{(PW-W){v[W-1]}}, v};
    endfunction

    // Full-precision complex product, one half-up rounding per component
    assign p_re = sx(x1_re) * sx(w1_re) - sx(x1_im) * sx(w1_im);
    assign p_im = sx(x1_re) * sx(w1_im) + sx(x1_im) * sx(w1_re);
    assign e_re = W'((p_re + RND) >>> F);
    assign e_im = W'((p_im + RND) >>> F);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            d1_re   <= '0;
            d1_im   <= '0;
            x1_re   <= '0;
            x1_im   <= '0;
            w1_re   <= '0;
            w1_im   <= '0;
            out_vld <= 1'b0;
            d       <= '0;
            e       <= '0;
        end else begin
            v1      <= in_vld;
            d1_re   <= s_re;
            d1_im   <= s_im;
            x1_re   <= x_re;
            x1_im   <= x_im;
            w1_re   <= tw_re;
            w1_im   <= tw_im;
            out_vld <= v1;
            d       <= {d1_re, d1_im};
            e       <= {e_re, e_im};
        end
    end

endmodule

// File: rtl/fft_stage_tdm.sv
// Radix-2 DIF FFT stage, P bf_pipe lanes over G=N/(2P) groups; done pulses G+3 cycles after start.
// start is ignored while busy; FFT_STAGE_SCALE_EN selects a 1/2 gain per stage.
module fft_stage_tdm
    import fft_pkg::*;
#(
    parameter int N     = 16,
    parameter int MSB   = 16,
    parameter int STAGE = 0,
    parameter int P     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N*MSB-1:0] data_in,
    output logic [N*MSB-1:0] data_out,
    output logic             busy,
    output logic             done
);

    localparam int G    = N / (2 * P);
    localparam int H    = N >> (STAGE + 1);
    localparam int LOGN = $clog2(N);
    localparam int BW   = LOGN - 1;
    localparam int CW   = $clog2(G) + 1;
    localparam int W    = MSB / 2;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  g1, g2;
    logic           issue, capture, finish;
    logic [MSB-1:0] din_q    [N];
    logic [MSB-1:0] bank     [N];
    logic [MSB-1:0] bank_nxt [N];
    logic [W-1:0]   rom_re   [N/2];
    logic [W-1:0]   rom_im   [N/2];
    logic [P-1:0]   lane_vld;
    logic [MSB-1:0] lane_d   [P];
    logic [MSB-1:0] lane_e   [P];

    function automatic logic [LOGN-1:0] top_idx(input logic [CW-1:0] g, input int p);
        int b;
        b = int'(g) * P + p;
        return LOGN'((b / H) * 2 * H + (b % H));
    endfunction

    function automatic logic [LOGN-1:0] bot_idx(input logic [CW-1:0] g, input int p);
        return top_idx(g, p) + LOGN'(H);
    endfunction

    for (genvar b = 0; b < N/2; b++) begin : g_rom
        localparam tw_t TW = twiddle((b % H) << STAGE, N, tw_frac(MSB));
        assign rom_re[b] = W'(TW.re);
        assign rom_im[b] = W'(TW.im);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        capture = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = ISSUE;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (cnt_q == CW'(G - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                // Second drain cycle is when the last group lands in the bank
                if (cnt_q == CW'(1)) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            g1      <= '0;
            g2      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            g1      <= cnt_q;
            g2      <= g1;
        end
    end

    assign busy = (state_q != IDLE);

    for (genvar p = 0; p < P; p++) begin : g_lane
        logic [LOGN-1:0] ti, bi;
        logic [BW-1:0]   wi;
        assign ti = top_idx(cnt_q, p);
        assign bi = bot_idx(cnt_q, p);
        assign wi = BW'(int'(cnt_q) * P + p);

        bf_pipe #(.MSB(MSB)) u_bf (
            .clk     (clk),
            .rst_n   (rst_n),
            .in_vld  (issue),
            .a       (din_q[ti]),
            .b       (din_q[bi]),
            .tw_re   (rom_re[wi]),
            .tw_im   (rom_im[wi]),
            .out_vld (lane_vld[p]),
            .d       (lane_d[p]),
            .e       (lane_e[p])
        );
    end

    always_comb begin
        bank_nxt = bank;
        for (int p = 0; p < P; p++) begin
            if (lane_vld[p]) begin
                bank_nxt[top_idx(g2, p)] = lane_d[p];
                bank_nxt[bot_idx(g2, p)] = lane_e[p];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                din_q[i] <= '0;
                bank[i]  <= '0;
            end
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            if (capture) begin
                for (int i = 0; i < N; i++) din_q[i] <= data_in[i*MSB +: MSB];
            end
            bank <= bank_nxt;
            done <= finish;
            if (finish) begin
                for (int i = 0; i < N; i++) data_out[i*MSB +: MSB] <= bank_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_fft_stage_tdm.sv
// Bench for fft_stage_tdm: three configurations, table of passes scored against a reference model.
module tb_fft_stage_tdm;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_a, start_b, start_c;
    logic [127:0] din_a, dout_a, din_b, dout_b;
    logic [255:0] din_c, dout_c;
    logic         busy_a, busy_b, busy_c, done_a, done_b, done_c;

    int checks = 0;
    int errors = 0;
    logic [255:0] sb[$];

`ifdef FFT_STAGE_SCALE_EN
    localparam bit SCALE = 1'b1;
`else
    localparam bit SCALE = 1'b0;
`endif

    typedef struct {
        int           inst;
        logic [255:0] din;
        logic [255:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    fft_stage_tdm #(.N(8), .MSB(16), .STAGE(0), .P(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .data_in(din_a),
        .data_out(dout_a), .busy(busy_a), .done(done_a));
    fft_stage_tdm #(.N(8), .MSB(16), .STAGE(0), .P(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .data_in(din_b),
        .data_out(dout_b), .busy(busy_b), .done(done_b));
    fft_stage_tdm #(.N(16), .MSB(16), .STAGE(3), .P(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .data_in(din_c),
        .data_out(dout_c), .busy(busy_c), .done(done_c));

    function automatic int s8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [7:0] lo8(input int v);
        logic [31:0] t;
        t = v;
        return t[7:0];
    endfunction

    function automatic int rnd_q6(input real x);
        return (x >= 0.0) ? $rtoi(x * 64.0 + 0.5) : -$rtoi(0.5 - x * 64.0);
    endfunction

    // Bit-exact reference for one stage pass, MSB=16 (8-bit re/im, Q2.6 twiddles)
    function automatic logic [255:0] model(input logic [255:0] din, input int n, input int stage);
        logic [255:0] r;
        int h, top, bot, k, ar, ai, br, bi, sr, si, xr, xi, wr, wi;
        real ang;
        r = '0;
        h = n >> (stage + 1);
        for (int bf = 0; bf < n / 2; bf++) begin
            top = (bf / h) * 2 * h + (bf % h);
            bot = top + h;
            k   = (bf % h) << stage;
            ar  = s8(din[top*16+8 +: 8]);
            ai  = s8(din[top*16 +: 8]);
            br  = s8(din[bot*16+8 +: 8]);
            bi  = s8(din[bot*16 +: 8]);
            if (SCALE) begin
                sr = (ar + br) >>> 1;  si = (ai + bi) >>> 1;
                xr = (ar - br) >>> 1;  xi = (ai - bi) >>> 1;
            end else begin
                sr = s8(lo8(ar + br)); si = s8(lo8(ai + bi));
                xr = s8(lo8(ar - br)); xi = s8(lo8(ai - bi));
            end
            ang = 6.283185307179586 * real'(k) / real'(n);
            wr  = rnd_q6($cos(ang));
            wi  = rnd_q6(-$sin(ang));
            r[top*16 +: 16] = {lo8(sr), lo8(si)};
            r[bot*16 +: 16] = {lo8((xr * wr - xi * wi + 32) >>> 6), lo8((xr * wi + xi * wr + 32) >>> 6)};
        end
        return r;
    endfunction

    function automatic logic [255:0] rnd_vec(input int n);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i*16 +: 16] = 16'($urandom);
        return v;
    endfunction

    function automatic int n_of(input int inst);     return (inst == 2) ? 16 : 8; endfunction
    function automatic int stage_of(input int inst); return (inst == 2) ? 3 : 0;  endfunction
    function automatic int grp_of(input int inst);   return (inst == 0) ? 4 : (inst == 1) ? 2 : 1; endfunction

    function automatic logic [255:0] get_out(input int inst);
        case (inst)
            0:       return {128'd0, dout_a};
            1:       return {128'd0, dout_b};
            default: return dout_c;
        endcase
    endfunction

    function automatic logic get_busy(input int inst);
        return (inst == 0) ? busy_a : (inst == 1) ? busy_b : busy_c;
    endfunction

    function automatic logic get_done(input int inst);
        return (inst == 0) ? done_a : (inst == 1) ? done_b : done_c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int inst, input logic s, input logic [255:0] din);
        case (inst)
            0:       begin start_a = s; din_a = din[127:0]; end
            1:       begin start_b = s; din_b = din[127:0]; end
            default: begin start_c = s; din_c = din; end
        endcase
    endtask

    task automatic chk_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Start one pass in the current cycle and follow it to done
    task automatic run_pass(input int inst, input logic [255:0] din, input logic [255:0] exp, input string name);
        int g, c, bad_busy, bad_hold;
        bit seen;
        logic [255:0] held, want;
        g = grp_of(inst);
        bad_busy = 0;
        bad_hold = 0;
        seen = 1'b0;
        drive(inst, 1'b1, din);
        sb.push_back(exp);
        tick();
        drive(inst, 1'b0, din);
        held = get_out(inst);
        c = 1;
        while (!seen && c <= g + 8) begin
            if (get_busy(inst) !== (c <= g + 2)) bad_busy++;
            if (get_done(inst) === 1'b1) seen = 1'b1;
            else begin
                if (get_out(inst) !== held) bad_hold++;
                tick();
                c++;
            end
        end
        chk_int({name, "_latency"}, seen ? c : -1, g + 3);
        chk_int({name, "_busy"}, bad_busy, 0);
        chk_int({name, "_hold"}, bad_hold, 0);
        want = sb.pop_front();
        chk_vec({name, "_data"}, get_out(inst), want);
    endtask

    task automatic seq_overlap();
        logic [255:0] d1, d2, d3, cur;
        int bad_busy, bad_done, ndone;
        logic exp_busy, exp_done;
        d1 = rnd_vec(8);
        d2 = rnd_vec(8);
        d3 = rnd_vec(8);
        bad_busy = 0;
        bad_done = 0;
        ndone = 0;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) begin
                exp_busy = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
                exp_done = (c == 5) || (c == 10);
                if (busy_b !== exp_busy) bad_busy++;
                if (done_b !== exp_done) bad_done++;
                if (done_b === 1'b1) begin
                    ndone++;
                    if (sb.size() == 0) chk_int("overlap_unexpected_done", c, -1);
                    else chk_vec("overlap_data", {128'd0, dout_b}, sb.pop_front());
                end
            end
            cur = (c == 0) ? d1 : (c == 2) ? d2 : d3;
            drive(1, (c == 0 || c == 2 || c == 5), cur);
            if (c == 0) sb.push_back(model(d1, 8, 0));
            if (c == 5) sb.push_back(model(d3, 8, 0));
            tick();
        end
        drive(1, 1'b0, d3);
        chk_int("overlap_busy", bad_busy, 0);
        chk_int("overlap_done", bad_done, 0);
        chk_int("overlap_ndone", ndone, 2);
        chk_int("overlap_sb_left", sb.size(), 0);
    endtask

    task automatic seq_reset_abort();
        logic [255:0] d;
        int bad;
        d = rnd_vec(8);
        drive(1, 1'b1, d);
        tick();
        drive(1, 1'b0, d);
        tick();
        rst_n = 1'b0;
        #1;
        chk_vec("abort_dout", {128'd0, dout_b}, '0);
        chk_int("abort_busy", int'(busy_b), 0);
        #2 rst_n = 1'b1;
        tick();
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (done_b !== 1'b0 || busy_b !== 1'b0 || dout_b !== '0) bad++;
            tick();
        end
        chk_int("abort_quiet", bad, 0);
        d = rnd_vec(8);
        run_pass(1, d, model(d, 8, 0), "after_abort");
    endtask

    initial begin
        vec_t tbl[9];
        logic [255:0] v, e;

        rst_n = 1'b0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        drive(2, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk_int("rst_busy", int'({busy_a, busy_b, busy_c}), 0);
        chk_int("rst_done", int'({done_a, done_b, done_c}), 0);
        chk_vec("rst_dout", dout_c ^ {128'd0, dout_a} ^ {dout_b, 128'd0}, '0);

        v = '0; v[0*16 +: 16] = 16'h4000;
        e = '0;
        if (SCALE) begin e[0*16 +: 16] = 16'h2000; e[4*16 +: 16] = 16'h2000; end
        else       begin e[0*16 +: 16] = 16'h4000; e[4*16 +: 16] = 16'h4000; end
        tbl[0] = '{0, v, e};

        v = '0; v[1*16 +: 16] = 16'h4000;
        e = '0;
        if (SCALE) begin e[1*16 +: 16] = 16'h2000; e[5*16 +: 16] = 16'h17EA; end
        else       begin e[1*16 +: 16] = 16'h4000; e[5*16 +: 16] = 16'h2DD3; end
        tbl[1] = '{0, v, e};

        v = '0;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = 16'h0A00;
        e = '0;
        for (int i = 0; i < 4; i++) e[i*16 +: 16] = SCALE ? 16'h0A00 : 16'h1400;
        tbl[2] = '{0, v, e};

        v = '0;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = (i < 4) ? 16'h7F7F : 16'h8081;
        tbl[3] = '{1, v, model(v, 8, 0)};

        for (int t = 4; t < 9; t++) begin
            tbl[t].inst = (t < 6) ? t - 4 : 2;
            tbl[t].din  = rnd_vec(n_of(tbl[t].inst));
            tbl[t].exp  = model(tbl[t].din, n_of(tbl[t].inst), stage_of(tbl[t].inst));
        end

        #3 rst_n = 1'b1;
        tick();

        for (int t = 0; t < 9; t++) begin
            run_pass(tbl[t].inst, tbl[t].din, tbl[t].exp, $sformatf("vec%0d", t));
        end

        tick();
        seq_overlap();
        seq_reset_abort();

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
